// File: rtl/register_file.sv
// register_file: eight 16-bit general-purpose registers (R0-R7) plus a 4-bit
// status register, feeding the function unit operands in the datapath.
//
// Ports:
//   clk        sole clock, state updates on rising edge
//   rst        asynchronous active-high reset, clears registers and status
//   RW         register write enable
//   DA         write address
//   D_in       write data
//   AA, BA     read addresses for operand ports A and B
//   A_data     R[AA], combinational
//   B_data     R[BA], combinational
//   FL         flag load enable
//   V_in, C_in, N_in, Z_in   flags from the function unit
//   status     latched flags {V,C,N,Z}
//   disp_addr  display read address
//   disp_data  R[disp_addr], combinational
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        RW,
  input  logic [2:0]  DA,
  input  logic [15:0] D_in,
  input  logic [2:0]  AA,
  input  logic [2:0]  BA,
  output logic [15:0] A_data,
  output logic [15:0] B_data,
  input  logic        FL,
  input  logic        V_in,
  input  logic        C_in,
  input  logic        N_in,
  input  logic        Z_in,
  output logic [3:0]  status,
  input  logic [2:0]  disp_addr,
  output logic [15:0] disp_data
);

  logic [15:0] regs [8];

  // Write port and flag register share the edge but are otherwise independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
      status <= 4'b0000;
    end else begin
      if (RW) begin
        regs[DA] <= D_in;
      end
      if (FL) begin
        status <= {V_in, C_in, N_in, Z_in};
      end
    end
  end

  // Reads come straight from storage; no bypass of the data being written.
  assign A_data    = regs[AA];
  assign B_data    = regs[BA];
  assign disp_data = regs[disp_addr];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        RW;
  logic [2:0]  DA;
  logic [15:0] D_in;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic [15:0] A_data;
  logic [15:0] B_data;
  logic        FL;
  logic        V_in;
  logic        C_in;
  logic        N_in;
  logic        Z_in;
  logic [3:0]  status;
  logic [2:0]  disp_addr;
  logic [15:0] disp_data;

  int vectors;
  int miscompares;

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .RW        (RW),
    .DA        (DA),
    .D_in      (D_in),
    .AA        (AA),
    .BA        (BA),
    .A_data    (A_data),
    .B_data    (B_data),
    .FL        (FL),
    .V_in      (V_in),
    .C_in      (C_in),
    .N_in      (N_in),
    .Z_in      (Z_in),
    .status    (status),
    .disp_addr (disp_addr),
    .disp_data (disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read register a on all three ports and compare with exp.
  task automatic read_all(input string tag, input logic [2:0] a, input logic [15:0] exp);
    AA = a;
    BA = a;
    disp_addr = a;
    #1;
    check({tag, "_A"}, A_data, exp);
    check({tag, "_B"}, B_data, exp);
    check({tag, "_D"}, disp_data, exp);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    RW = 1'b0;
    DA = 3'd0;
    D_in = 16'h0000;
    AA = 3'd0;
    BA = 3'd0;
    FL = 1'b0;
    V_in = 1'b0;
    C_in = 1'b0;
    N_in = 1'b0;
    Z_in = 1'b0;
    disp_addr = 3'd0;

    // Power-on reset state
    #2;
    read_all("por_r0", 3'd0, 16'h0000);
    check("por_status", {12'h000, status}, 16'h0000);
    tick();
    rst = 1'b0;

    // Write R3 then an asynchronous reset pulse between edges
    RW = 1'b1; DA = 3'd3; D_in = 16'h1234;
    tick();
    RW = 1'b0;
    read_all("r3_written", 3'd3, 16'h1234);
    FL = 1'b1; V_in = 1'b1; C_in = 1'b1; N_in = 1'b1; Z_in = 1'b1;
    tick();
    FL = 1'b0;
    check("status_set", {12'h000, status}, 16'h000F);
    #1 rst = 1'b1;
    #1;
    check("async_rst_status", {12'h000, status}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      read_all("async_rst_reg", 3'(i), 16'h0000);
    end
    rst = 1'b0;

    // Write R[i] = 1111*i, then sweep
    tick();
    RW = 1'b1;
    for (int i = 0; i < 8; i++) begin
      DA = 3'(i);
      D_in = 16'(16'h1111 * i);
      tick();
    end
    RW = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_all("sweep", 3'(i), 16'(16'h1111 * i));
    end
    AA = 3'd2; BA = 3'd5; disp_addr = 3'd7;
    #1;
    check("mixed_A", A_data, 16'h2222);
    check("mixed_B", B_data, 16'h5555);
    check("mixed_D", disp_data, 16'h7777);

    // No write-through bypass
    RW = 1'b1; DA = 3'd4; D_in = 16'h00FF;
    tick();
    D_in = 16'hABCD; AA = 3'd4;
    #1;
    check("nobypass_before", A_data, 16'h00FF);
    tick();
    RW = 1'b0;
    check("nobypass_after", A_data, 16'hABCD);

    // RW=0 holds for three edges
    DA = 3'd1; D_in = 16'hFFFF; RW = 1'b0;
    tick(); tick(); tick();
    read_all("rw0_hold", 3'd1, 16'h1111);

    // Back-to-back writes to the same address: last one wins
    RW = 1'b1; DA = 3'd5; D_in = 16'h0A0A;
    tick();
    read_all("b2b_first", 3'd5, 16'h0A0A);
    D_in = 16'h0B0B;
    tick();
    RW = 1'b0;
    read_all("b2b_last", 3'd5, 16'h0B0B);

    // Flags with write-back: 7FFF + 0001 = 8000, V=1 C=0 N=1 Z=0
    RW = 1'b1; DA = 3'd7; D_in = 16'h7FFF;
    tick();
    DA = 3'd1; D_in = 16'h0001;
    tick();
    AA = 3'd7; BA = 3'd1; DA = 3'd6; D_in = 16'h8000;
    FL = 1'b1; V_in = 1'b1; C_in = 1'b0; N_in = 1'b1; Z_in = 1'b0;
    #1;
    check("opA", A_data, 16'h7FFF);
    check("opB", B_data, 16'h0001);
    tick();
    RW = 1'b0; FL = 1'b0; Z_in = 1'b1;
    read_all("r6_sum", 3'd6, 16'h8000);
    check("flags_loaded", {12'h000, status}, 16'h000A);
    tick();
    check("flags_hold", {12'h000, status}, 16'h000A);

    // Reset across an edge with RW=1 and FL=1: no write, no flag load
    rst = 1'b1; RW = 1'b1; FL = 1'b1; DA = 3'd2; D_in = 16'h5555;
    V_in = 1'b1; C_in = 1'b1; N_in = 1'b1; Z_in = 1'b1;
    tick();
    read_all("rst_write_r2", 3'd2, 16'h0000);
    check("rst_write_status", {12'h000, status}, 16'h0000);

    // Writes resume on the first edge after reset falls
    rst = 1'b0; DA = 3'd0; D_in = 16'h0042;
    V_in = 1'b0; C_in = 1'b1; N_in = 1'b0; Z_in = 1'b1;
    tick();
    RW = 1'b0; FL = 1'b0;
    read_all("post_rst_r0", 3'd0, 16'h0042);
    check("post_rst_status", {12'h000, status}, 16'h0005);
    read_all("post_rst_r6", 3'd6, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
